// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-client (iCache / dCache) arbiter onto a single line-wide
//                memory port. Fair alternation under contention, one-cycle
//                Ready pulse per transaction, one cool-down cycle between
//                transactions so a requester can drop its level request.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter #(
  parameter int WORD_SIZE = 32,
  parameter int LINE_SIZE = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  // iCache side
  input  logic                 ICReq,
  input  logic [WORD_SIZE-1:0] ICAddr,
  output logic [LINE_SIZE-1:0] ICLine,
  output logic                 ICReady,
  // dCache side
  input  logic                 DCReq,
  input  logic                 DCWrite,
  input  logic [WORD_SIZE-1:0] DCAddr,
  input  logic [LINE_SIZE-1:0] DCWLine,
  output logic [LINE_SIZE-1:0] DCLine,
  output logic                 DCReady,
  // memory side
  output logic                 MemReq,
  output logic                 MemWrite,
  output logic [WORD_SIZE-1:0] MemAddr,
  output logic [LINE_SIZE-1:0] MemWLine,
  input  logic [LINE_SIZE-1:0] MemRLine,
  input  logic                 MemReady,
  // status
  output logic [1:0]           Owner
);

  localparam logic [1:0] c_OWNER_NONE = 2'b00;
  localparam logic [1:0] c_OWNER_IC   = 2'b01;
  localparam logic [1:0] c_OWNER_DC   = 2'b10;

  // LastWinner encoding: 0 = iCache won last, 1 = dCache won last
  localparam logic c_LAST_IC = 1'b0;
  localparam logic c_LAST_DC = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2,
    S_COOL = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;

  logic                   w_grant_ic;
  logic                   w_grant_dc;
  logic                   w_complete;
  logic                   w_clear_owner;

  logic                   r_last_winner;
  logic [1:0]             r_owner;
  logic                   r_mem_req;
  logic                   r_mem_write;
  logic [WORD_SIZE-1:0]   r_mem_addr;
  logic [LINE_SIZE-1:0]   r_mem_wline;
  logic [LINE_SIZE-1:0]   r_ic_line;
  logic [LINE_SIZE-1:0]   r_dc_line;
  logic                   r_ic_ready;
  logic                   r_dc_ready;

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and per-cycle control strobes for the datapath.
  always_comb begin
    w_next_state  = r_state;
    w_grant_ic    = 1'b0;
    w_grant_dc    = 1'b0;
    w_complete    = 1'b0;
    w_clear_owner = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (ICReq && DCReq) begin
          // Contention: the side that did not win last time goes first.
          if (r_last_winner == c_LAST_IC) begin
            w_grant_dc = 1'b1;
          end else begin
            w_grant_ic = 1'b1;
          end
        end else if (ICReq) begin
          w_grant_ic = 1'b1;
        end else if (DCReq) begin
          w_grant_dc = 1'b1;
        end
        if (ICReq || DCReq) begin
          w_next_state = S_BUSY;
        end
      end
      S_BUSY: begin
        // MemReady is only meaningful here; elsewhere it is ignored.
        if (MemReady) begin
          w_complete   = 1'b1;
          w_next_state = S_RESP;
        end
      end
      S_RESP: begin
        w_next_state = S_COOL;
      end
      S_COOL: begin
        // Requests are not looked at in this cycle, giving the requester a
        // clock edge to drop its level request after seeing Ready.
        w_clear_owner = 1'b1;
        w_next_state  = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Datapath: grant latching, memory handshake, line capture, Ready pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_winner <= c_LAST_IC;
      r_owner       <= c_OWNER_NONE;
      r_mem_req     <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wline   <= '0;
      r_ic_line     <= '0;
      r_dc_line     <= '0;
      r_ic_ready    <= 1'b0;
      r_dc_ready    <= 1'b0;
    end else begin
      // Ready is a single-cycle pulse: it is only ever set on completion and
      // falls back on the following edge.
      r_ic_ready <= 1'b0;
      r_dc_ready <= 1'b0;

      if (w_grant_ic) begin
        // iCache only reads, so the write-data register is left as is.
        r_owner       <= c_OWNER_IC;
        r_mem_req     <= 1'b1;
        r_mem_write   <= 1'b0;
        r_mem_addr    <= ICAddr;
        r_last_winner <= c_LAST_IC;
      end

      if (w_grant_dc) begin
        r_owner       <= c_OWNER_DC;
        r_mem_req     <= 1'b1;
        r_mem_write   <= DCWrite;
        r_mem_addr    <= DCAddr;
        r_mem_wline   <= DCWLine;
        r_last_winner <= c_LAST_DC;
      end

      if (w_complete) begin
        r_mem_req <= 1'b0;
        if (r_owner == c_OWNER_DC) begin
          r_dc_ready <= 1'b1;
          if (!r_mem_write) begin
            r_dc_line <= MemRLine;
          end
        end else begin
          r_ic_ready <= 1'b1;
          if (!r_mem_write) begin
            r_ic_line <= MemRLine;
          end
        end
      end

      if (w_clear_owner) begin
        r_owner <= c_OWNER_NONE;
      end
    end
  end

  assign ICLine   = r_ic_line;
  assign ICReady  = r_ic_ready;
  assign DCLine   = r_dc_line;
  assign DCReady  = r_dc_ready;
  assign MemReq   = r_mem_req;
  assign MemWrite = r_mem_write;
  assign MemAddr  = r_mem_addr;
  assign MemWLine = r_mem_wline;
  assign Owner    = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Scoreboard bench for mem_arbiter. Stimulus pushes expected
//                memory requests and expected Ready responses into queues; a
//                memory-model process and a Ready monitor pop and compare.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int WS = 32;
  localparam int LS = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          ICReq;
  logic [WS-1:0] ICAddr;
  logic [LS-1:0] ICLine;
  logic          ICReady;
  logic          DCReq;
  logic          DCWrite;
  logic [WS-1:0] DCAddr;
  logic [LS-1:0] DCWLine;
  logic [LS-1:0] DCLine;
  logic          DCReady;
  logic          MemReq;
  logic          MemWrite;
  logic [WS-1:0] MemAddr;
  logic [LS-1:0] MemWLine;
  logic [LS-1:0] MemRLine;
  logic          MemReady;
  logic [1:0]    Owner;

  mem_arbiter #(.WORD_SIZE(WS), .LINE_SIZE(LS)) dut (
    .clk(clk), .rst(rst),
    .ICReq(ICReq), .ICAddr(ICAddr), .ICLine(ICLine), .ICReady(ICReady),
    .DCReq(DCReq), .DCWrite(DCWrite), .DCAddr(DCAddr), .DCWLine(DCWLine),
    .DCLine(DCLine), .DCReady(DCReady),
    .MemReq(MemReq), .MemWrite(MemWrite), .MemAddr(MemAddr),
    .MemWLine(MemWLine), .MemRLine(MemRLine), .MemReady(MemReady),
    .Owner(Owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          is_dc;
    logic [LS-1:0] line;
  } rsp_t;

  typedef struct {
    logic [WS-1:0] addr;
    logic          write;
    logic          chk_wline;
    logic [LS-1:0] wline;
    logic [1:0]    owner;
  } mreq_t;

  rsp_t  rsp_q[$];
  mreq_t mreq_q[$];

  int n_cmp = 0;
  int n_err = 0;

  logic [LS-1:0] mem [logic [WS-1:0]];
  int            mem_lat  = 3;
  logic          spur_req = 1'b0;
  logic          spur_ack = 1'b0;

  localparam logic [LS-1:0] LINE_A   = {32{4'hA}};
  localparam logic [LS-1:0] LINE_SPUR = {32{4'h5}};

  function automatic void check(input string nm, input logic [LS-1:0] act, input logic [LS-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic void fail_event(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event occurred (got 1 expected 0)", nm);
  endfunction

  function automatic logic [LS-1:0] lookup(input logic [WS-1:0] a);
    if (mem.exists(a)) return mem[a];
    return {4{a}};
  endfunction

  // Memory model: answers each MemReq after mem_lat cycles, checks the
  // request fields against the expected-request queue, and can inject a
  // stray MemReady on demand.
  int    mem_cnt  = -1;
  logic  prev_mreq = 1'b0;
  mreq_t cur_req;
  always @(negedge clk) begin
    MemReady = 1'b0;
    if (spur_req != spur_ack) begin
      spur_ack = spur_req;
      MemReady = 1'b1;
      MemRLine = LINE_SPUR;
    end
    if (!MemReq) begin
      mem_cnt = -1;
    end else if (!prev_mreq) begin
      mem_cnt = mem_lat;
      if (mreq_q.size() == 0) begin
        fail_event("unexpected_memreq");
        cur_req = '{MemAddr, MemWrite, 1'b0, '0, Owner};
      end else begin
        cur_req = mreq_q.pop_front();
        check("mem_addr", MemAddr, cur_req.addr);
        check("mem_write", MemWrite, cur_req.write);
        check("owner_at_grant", Owner, cur_req.owner);
        if (cur_req.chk_wline) check("mem_wline", MemWLine, cur_req.wline);
      end
    end else if (mem_cnt > 0) begin
      mem_cnt--;
    end
    if (MemReq && mem_cnt == 0) begin
      check("mem_addr_stable", MemAddr, cur_req.addr);
      MemReady = 1'b1;
      MemRLine = lookup(MemAddr);
      mem_cnt  = -1;
    end
    prev_mreq = MemReq;
  end

  // Ready monitor: every Ready pulse must match the next expected response.
  logic prev_ic_rdy = 1'b0;
  logic prev_dc_rdy = 1'b0;
  rsp_t r;
  always @(negedge clk) begin
    if (ICReady && DCReady) fail_event("both_ready");
    if (ICReady && prev_ic_rdy) fail_event("ic_ready_width");
    if (DCReady && prev_dc_rdy) fail_event("dc_ready_width");
    if (ICReady || DCReady) begin
      if (rsp_q.size() == 0) begin
        fail_event("unexpected_ready");
      end else begin
        r = rsp_q.pop_front();
        check("ready_port_is_dc", DCReady, r.is_dc);
        if (r.is_dc) check("dc_line", DCLine, r.line);
        else         check("ic_line", ICLine, r.line);
      end
    end
    prev_ic_rdy = ICReady;
    prev_dc_rdy = DCReady;
  end

  // Wait for a port's Ready, hold the request 'hold' more cycles, then drop.
  task automatic wait_port(input bit dc, input int hold);
    int n = 0;
    while (!(dc ? DCReady : ICReady) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_event(dc ? "dc_ready_timeout" : "ic_ready_timeout");
    repeat (hold) @(negedge clk);
    if (dc) DCReq = 1'b0;
    else    ICReq = 1'b0;
  endtask

  // Both caches request reads in the same cycle; dCache is expected first.
  task automatic contend_dc_first(input logic [WS-1:0] ia, input logic [WS-1:0] da);
    int n = 0;
    bit ic_p = 1'b1;
    bit dc_p = 1'b1;
    mreq_q.push_back('{da, 1'b0, 1'b0, '0, 2'b10});
    mreq_q.push_back('{ia, 1'b0, 1'b0, '0, 2'b01});
    rsp_q.push_back('{1'b1, lookup(da)});
    rsp_q.push_back('{1'b0, lookup(ia)});
    DCWrite = 1'b0;
    ICAddr  = ia;
    DCAddr  = da;
    ICReq   = 1'b1;
    DCReq   = 1'b1;
    while ((ic_p || dc_p) && n < 200) begin
      @(negedge clk);
      n++;
      if (DCReady) begin DCReq = 1'b0; dc_p = 1'b0; end
      if (ICReady) begin ICReq = 1'b0; ic_p = 1'b0; end
    end
    if (ic_p || dc_p) fail_event("contend_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; ICReq = 1'b0; ICAddr = '0; DCReq = 1'b0; DCWrite = 1'b0;
    DCAddr = '0; DCWLine = '0; MemRLine = '0; MemReady = 1'b0;
    mem[32'h40]  = LINE_A;
    mem[32'h80]  = 128'hC3C3_0000_1111_2222_3333_4444_5555_C3C3;
    mem[32'h200] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    mem[32'h300] = 128'hDEAD_BEEF_0000_0001_CAFE_F00D_0000_0002;
    repeat (2) @(negedge clk);

    // Reset values
    check("rst_memreq", MemReq, 0);
    check("rst_memwrite", MemWrite, 0);
    check("rst_memaddr", MemAddr, 0);
    check("rst_memwline", MemWLine, 0);
    check("rst_icline", ICLine, 0);
    check("rst_dcline", DCLine, 0);
    check("rst_owner", Owner, 0);
    check("rst_readys", {ICReady, DCReady}, 0);
    rst = 1'b1;
    @(negedge clk);

    // iCache read of 0x40, memory answers after 3 cycles
    mreq_q.push_back('{32'h40, 1'b0, 1'b0, '0, 2'b01});
    rsp_q.push_back('{1'b0, LINE_A});
    ICAddr = 32'h40;
    ICReq  = 1'b1;
    @(negedge clk);
    check("memreq_one_cycle_after_req", MemReq, 1);
    check("owner_ic_busy", Owner, 2'b01);
    wait_port(1'b0, 0);
    check("owner_ic_resp", Owner, 2'b01);
    repeat (2) @(negedge clk);
    check("owner_none_after_cool", Owner, 2'b00);

    // dCache write-back: DCLine must not change
    mreq_q.push_back('{32'h100, 1'b1, 1'b1, 128'h1234, 2'b10});
    rsp_q.push_back('{1'b1, '0});
    DCAddr = 32'h100; DCWrite = 1'b1; DCWLine = 128'h1234; DCReq = 1'b1;
    wait_port(1'b1, 0);
    DCWrite = 1'b0;
    repeat (2) @(negedge clk);
    check("dcline_after_write", DCLine, 0);

    // dCache read of 0x200
    mreq_q.push_back('{32'h200, 1'b0, 1'b0, '0, 2'b10});
    rsp_q.push_back('{1'b1, mem[32'h200]});
    DCAddr = 32'h200; DCReq = 1'b1;
    wait_port(1'b1, 0);
    repeat (2) @(negedge clk);
    check("icline_held", ICLine, LINE_A);

    // iCache holds its request through the cool-down cycle: no second grant
    mreq_q.push_back('{32'h80, 1'b0, 1'b0, '0, 2'b01});
    rsp_q.push_back('{1'b0, mem[32'h80]});
    ICAddr = 32'h80; ICReq = 1'b1;
    wait_port(1'b0, 2);
    repeat (6) @(negedge clk);
    check("no_regrant_memreq", MemReq, 0);
    check("no_regrant_owner", Owner, 2'b00);

    // Request dropped while BUSY still completes
    mreq_q.push_back('{32'h40, 1'b0, 1'b0, '0, 2'b01});
    rsp_q.push_back('{1'b0, LINE_A});
    ICAddr = 32'h40; ICReq = 1'b1;
    @(negedge clk);
    ICReq = 1'b0;
    wait_port(1'b0, 0);
    repeat (3) @(negedge clk);

    // Stray MemReady in IDLE must change nothing
    spur_req = ~spur_req;
    repeat (3) @(negedge clk);
    check("spur_owner", Owner, 2'b00);
    check("spur_memreq", MemReq, 0);
    check("spur_icline", ICLine, LINE_A);
    check("spur_dcline", DCLine, mem[32'h200]);

    // Reset during BUSY abandons the transaction
    mem_lat = 20;
    mreq_q.push_back('{32'h300, 1'b0, 1'b0, '0, 2'b10});
    DCAddr = 32'h300; DCReq = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", MemReq, 1);
    rst = 1'b0;
    #1;
    check("midrst_memreq", MemReq, 0);
    check("midrst_memaddr", MemAddr, 0);
    check("midrst_owner", Owner, 0);
    check("midrst_dcline", DCLine, 0);
    check("midrst_icline", ICLine, 0);
    check("midrst_readys", {ICReady, DCReady}, 0);
    DCReq = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (25) @(negedge clk);
    check("post_rst_owner", Owner, 0);
    check("post_rst_memreq", MemReq, 0);
    mem_lat = 3;

    // Contention after reset: dCache, then iCache, then dCache again
    contend_dc_first(32'h80, 32'h300);
    contend_dc_first(32'h40, 32'h200);

    repeat (5) @(negedge clk);
    check("rsp_queue_drained", rsp_q.size(), 0);
    check("mreq_queue_drained", mreq_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
